// File: rtl/mr_wb_timer.sv
// 64-bit machine timer (mtime/mtimecmp) with prescaler and level interrupt,
// exposed as a pipelined Wishbone slave with single-cycle registered responses.
module mr_wb_timer #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned XLEN_GRAN    = 2,
  parameter logic [15:0] PRESCALE_RST = 16'd0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [XLEN-XLEN_GRAN-1:0] addr_i,
  input  logic [XLEN-1:0]           dat_i,
  input  logic [XLEN/8-1:0]         sel_i,
  input  logic                      we_i,
  input  logic                      stb_i,
  input  logic                      cyc_i,
  output logic                      ack_o,
  output logic                      err_o,
  output logic                      stall_o,
  output logic [XLEN-1:0]           dat_o,
  output logic                      timer_irq
);

  logic        acc;
  logic [2:0]  off;
  logic        tick;
  logic        cmp_ge;
  logic        unused_addr;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [31:0] shadow_q, shadow_d;
  logic        en_q, en_d;
  logic        irq_en_q, irq_en_d;
  logic [15:0] pre_q, pre_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        irq_q, irq_d;
  logic [XLEN-1:0] dat_q, dat_d;

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int unsigned b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  assign acc         = cyc_i & stb_i;
  assign off         = addr_i[2:0];
  assign unused_addr = ^addr_i[XLEN-XLEN_GRAN-1:3];
  assign cmp_ge      = (mtime_q >= mtimecmp_q);
  assign tick        = en_q && (pcnt_q == pre_q);

  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    shadow_d   = shadow_q;
    en_d       = en_q;
    irq_en_d   = irq_en_q;
    pre_d      = pre_q;
    pcnt_d     = pcnt_q;
    dat_d      = dat_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    irq_d      = irq_en_q & cmp_ge;

    if (en_q) pcnt_d = tick ? '0 : pcnt_q + 16'd1;
    if (tick) mtime_d = mtime_q + 64'd1;

    if (acc) begin
      if (off == 3'd7) err_d = 1'b1;
      else             ack_d = 1'b1;

      if (we_i) begin
        dat_d = '0;
      end else begin
        unique case (off)
          3'd0:    dat_d = mtime_q[31:0];
          3'd1:    dat_d = shadow_q;
          3'd2:    dat_d = mtimecmp_q[31:0];
          3'd3:    dat_d = mtimecmp_q[63:32];
          3'd4:    dat_d = {30'd0, irq_en_q, en_q};
          3'd5:    dat_d = {16'd0, pre_q};
          3'd6:    dat_d = {31'd0, cmp_ge};
          default: dat_d = '0;
        endcase
        if (off == 3'd0) shadow_d = mtime_q[63:32];
      end

      // A bus write to mtime overrides this cycle's tick, built from the pre-tick value.
      if (we_i) begin
        unique case (off)
          3'd0: mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], dat_i, sel_i)};
          3'd1: mtime_d = {merge(mtime_q[63:32], dat_i, sel_i), mtime_q[31:0]};
          3'd2: mtimecmp_d = {mtimecmp_q[63:32], merge(mtimecmp_q[31:0], dat_i, sel_i)};
          3'd3: mtimecmp_d = {merge(mtimecmp_q[63:32], dat_i, sel_i), mtimecmp_q[31:0]};
          3'd4: begin
            if (sel_i[0]) begin
              en_d     = dat_i[0];
              irq_en_d = dat_i[1];
            end
          end
          3'd5: begin
            if (sel_i[0]) pre_d[7:0]  = dat_i[7:0];
            if (sel_i[1]) pre_d[15:8] = dat_i[15:8];
            pcnt_d = '0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      shadow_q   <= '0;
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      pre_q      <= PRESCALE_RST;
      pcnt_q     <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      irq_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      shadow_q   <= shadow_d;
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      pre_q      <= pre_d;
      pcnt_q     <= pcnt_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      irq_q      <= irq_d;
      dat_q      <= dat_d;
    end
  end

  // Responses are dropped if the master abandons the cycle before they arrive.
  assign ack_o     = ack_q & cyc_i;
  assign err_o     = err_q & cyc_i;
  assign stall_o   = 1'b0;
  assign dat_o     = dat_q;
  assign timer_irq = irq_q;

endmodule

// File: doc/mr_wb_timer.md
# mr_wb_timer

Memory-mapped 64-bit machine timer (mtime/mtimecmp) with a prescaler and a level timer interrupt. It is a pipelined Wishbone slave that sits downstream of the core's bus arbiter, beside the RAM. The address decode in front of it asserts `stb_i` only for this block's window. It gives software a free-running time base and a compare interrupt for scheduling.

## Interface
Parameters:
- `PRESCALE_RST`, default 0: reset value of the PRESCALE register; the timer ticks every PRESCALE+1 enabled cycles.

Ports:
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `addr_i`  in  `XLEN-XLEN_GRAN`  word address; only bits [2:0] are decoded (register offset).
- `dat_i`  in  `XLEN`  write data.
- `sel_i`  in  `XLEN/8`  byte enables for writes.
- `we_i`  in  1  write enable.
- `stb_i`  in  1  strobe.
- `cyc_i`  in  1  bus cycle active.
- `ack_o`  out  1  transfer complete.
- `err_o`  out  1  transfer error.
- `stall_o`  out  1  stall; tied 0.
- `dat_o`  out  `XLEN`  read data, valid with `ack_o`.
- `timer_irq`  out  1  level interrupt to the core.

## Operation
Register map (word offset, R/W):
- 0 MTIME_LO (RW).
- 1 MTIME_HI (RW; reads return the shadow).
- 2 MTIMECMP_LO (RW).
- 3 MTIMECMP_HI (RW).
- 4 CTRL (RW): bit0 EN, bit1 IRQ_EN; other bits read 0.
- 5 PRESCALE (RW): bits [15:0]; other bits read 0.
- 6 STATUS (RO): bit0 = mtime >= mtimecmp (live compare); writes ignored but acked.
- 7 reserved: any access gets `err_o`, no state change.

Access rules:
- A request is accepted when `cyc_i & stb_i`; `stall_o` is always 0, so one request is accepted per cycle.
- Writes honour `sel_i` per byte and commit at the end of the accept cycle.
- Reading MTIME_LO returns the live low word and copies the live mtime[63:32] into the shadow `mtime_hi_shadow`. Reading MTIME_HI returns the shadow, which gives software an atomic 64-bit read (LO then HI).

Counting:
- The prescale counter `pcnt` (16 bits) advances only while EN=1.
- When `pcnt == PRESCALE`: `pcnt` goes to 0 and mtime increments by 1 (full 64-bit carry, wraps 2^64-1 to 0). Otherwise `pcnt` increments.
- EN=0 freezes both `pcnt` and mtime.
- Writing PRESCALE clears `pcnt` to 0.

Interrupt:
- `timer_irq` is registered: `timer_irq <= IRQ_EN & (mtime >= mtimecmp)`, unsigned 64-bit compare.
- Software clears it by raising mtimecmp or clearing IRQ_EN.

## Timing
Reset values (`rst_i` high at an edge):
- mtime = 0; mtimecmp = all ones; shadow = 0; CTRL = 0; PRESCALE = `PRESCALE_RST`; `pcnt` = 0.
- `ack_o` = 0, `err_o` = 0, `dat_o` = 0, `timer_irq` = 0, `stall_o` = 0.
- Reset asserted mid-transfer drops any pending response: no `ack_o` or `err_o` in the following cycle.

Response timing:
- A request accepted in cycle N gets exactly one of `ack_o`/`err_o` high in cycle N+1, with `dat_o` registered in N. Both responses are single-cycle pulses.
- Back-to-back requests get back-to-back responses.
- If `cyc_i` is low in N+1, that response is suppressed. A write accepted in N still commits (abort does not roll back).
- `dat_o` holds its last value when no response is given; read data for writes is don't-care (driven 0).

Precedence and boundaries:
- A bus write to MTIME_LO/HI in the same cycle as a tick takes precedence: the written bytes load, the unwritten half keeps its pre-tick value, and that tick's increment is lost.
- A read in cycle N returns state as of the start of N, so a write in N-1 is visible to a read in N.
- Carry from mtime[31:0] = 0xFFFFFFFF into the high word happens in the same tick.
- PRESCALE = 0 gives one tick per enabled cycle; PRESCALE = 0xFFFF gives one tick per 65536 enabled cycles.
- `timer_irq` lags a compare change (mtime tick, mtimecmp write, CTRL write) by exactly one cycle.

## Test plan
- Reset -> `timer_irq` = 0; read STATUS = 0; read MTIMECMP_LO = 0xFFFFFFFF, each acked in the next cycle.
- PRESCALE = 3, EN = 1; wait 40 cycles -> MTIME_LO = 10 (±1 for the write cycle); set EN = 0 -> value frozen across 20 idle cycles.
- MTIME_LO = 0xFFFFFFFF, MTIME_HI = 0, PRESCALE = 0, EN = 1 -> after one tick, LO read = 0x00000000 and HI read (shadow) = 1.
- MTIMECMP = 5 (HI = 0), IRQ_EN = 1, EN = 1, PRESCALE = 0, starting from mtime = 0 -> `timer_irq` rises one cycle after mtime reaches 5; writing MTIMECMP_LO = 100 drops it one cycle later.
- Access offset 7 -> `err_o` = 1 and `ack_o` = 0 in the next cycle. Byte write sel = 4'b0010, data 0x0000AB00 to MTIMECMP_LO -> reads 0xFFFFABFF.
- Back-to-back write CTRL = 3 then read CTRL in the next cycle -> two consecutive acks, read data = 3. A request with `cyc_i` dropped in the response cycle -> no `ack_o`.
